etapa_fetch: RTL and testbench
==============================

ETAPA_FETCH -- requirements
Module: etapa_fetch

Interface
REQ-001 The block SHALL have parameter PC_INICIAL, default 64'h0, byte address loaded into PC on reset.
REQ-002 The block SHALL have parameter PROFUNDIDAD, default 2, instruction-queue entries (legal 2..4).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port direccion  output  64  word index to instruction memory: {2'b00, PC[63:2]}.
REQ-006 The block SHALL have port instruccion_im  input  32  combinational read data returned for direccion in the same cycle.
REQ-007 The block SHALL have port salto  input  1  branch-taken redirect request from execute.
REQ-008 The block SHALL have port destino_salto  input  64  branch target byte address.
REQ-009 The block SHALL have port inst_valida  output  1  queue head valid towards decode.
REQ-010 The block SHALL have port decode_listo  input  1  decode accepts head this cycle.
REQ-011 The block SHALL have port instruccion  output  32  queue-head instruction.
REQ-012 The block SHALL have port pc_inst  output  64  byte address of queue-head instruction.
REQ-013 The block SHALL have port error_alineacion  output  1  sticky flag, misaligned branch target seen.

Function
REQ-014 PC SHALL be a 64-bit register; sequential next PC = PC + 4, 64-bit modular (wraps 0xFFFF_FFFF_FFFF_FFFC -> 0).
REQ-015 FSM states SHALL be ARRANQUE, BUSCANDO, LLENO.
REQ-016 ARRANQUE: entered by reset; no enqueue; next state BUSCANDO unconditionally after one cycle.
REQ-017 BUSCANDO: each cycle, if queue not full or a pop occurs that cycle, SHALL enqueue {instruccion_im, PC} and advance PC by 4.
REQ-018 BUSCANDO -> LLENO when the queue becomes full with no pop; LLENO -> BUSCANDO on the edge of the first pop.
REQ-019 LLENO: PC SHALL hold and no enqueue SHALL occur.
REQ-020 Transfer to decode SHALL occur on a rising edge with inst_valida=1 and decode_listo=1; instruccion/pc_inst SHALL be stable while inst_valida=1 and decode_listo=0.
REQ-021 inst_valida SHALL be 1 iff queue count > 0; outputs SHALL be driven from registers (no combinational path from instruccion_im).
REQ-022 Simultaneous push and pop on a full queue SHALL be allowed, count unchanged, order preserved (FIFO).
REQ-023 salto=1 SHALL have priority over all else: on that edge the queue is emptied, PC <= {destino_salto[63:2], 2'b00}, the instruction read that cycle is discarded, pop is ignored, state -> BUSCANDO.
REQ-024 If salto=1 and destino_salto[1:0] != 0, error_alineacion SHALL set to 1 and remain 1 until reset.
REQ-025 First instruction after redirect SHALL appear at inst_valida one cycle after the salto edge.
REQ-026 Queue pointers SHALL wrap modulo PROFUNDIDAD; count SHALL never exceed PROFUNDIDAD nor underflow.

Reset
REQ-027 On reset assertion, asynchronously: PC = PC_INICIAL, queue empty, inst_valida = 0, instruccion = 0, pc_inst = 0, error_alineacion = 0, state = ARRANQUE.
REQ-028 Reset asserted mid-operation SHALL discard all queued instructions and any pending salto.
REQ-029 direccion SHALL equal {2'b00, PC_INICIAL[63:2]} while reset is high.

Verification
REQ-030 Reset release, decode_listo=1, IM word k = k: inst_valida rises cycle 2; instruccion sequence 0,1,2,... with pc_inst 0,4,8,... one per cycle.
REQ-031 decode_listo=0 for 5 cycles from reset: queue fills to 2, state LLENO, PC holds 8, instruccion=0 stable; on decode_listo=1 stream resumes 0,1,2 with no loss or duplicate.
REQ-032 salto=1, destino_salto=0x40 while queue holds 2: next cycle inst_valida=0 then instruccion=IM[16], pc_inst=0x40; flushed entries never delivered.
REQ-033 salto=1, destino_salto=0x42: PC becomes 0x40, error_alineacion=1 and stays 1 across later aligned branches until reset.
REQ-034 Full queue, decode_listo=1 every cycle: push and pop same edge, count stays 2, order preserved.
REQ-035 Reset pulsed asynchronously mid-stream (between edges): outputs clear immediately; after release, fetch restarts from PC_INICIAL per REQ-030.

Source files
------------

// File: rtl/etapa_fetch.sv
// ---------------------------------------------------------------------------------------------
// etapa_fetch: instruction fetch stage with a small in-order instruction queue.
//
// PC walks instruction memory four bytes at a time. Each fetched word is queued together with
// its byte address, and decode drains the queue with a valid/ready handshake. A taken branch
// from execute flushes the queue and redirects PC. Branch targets are forced to word
// alignment, and a misaligned target sets a sticky error flag.
//
// Parameters
//   PC_INICIAL       byte address loaded into PC on reset
//   PROFUNDIDAD      instruction queue entries (2..4)
//
// Ports
//   clk              clock, all state on the rising edge
//   reset            asynchronous active-high reset
//   direccion        word index to instruction memory, {2'b00, PC[63:2]}
//   instruccion_im   combinational memory read data for direccion
//   salto            branch-taken redirect request
//   destino_salto    branch target byte address
//   inst_valida      queue head valid towards decode
//   decode_listo     decode accepts the head this cycle
//   instruccion      queue-head instruction
//   pc_inst          byte address of the queue-head instruction
//   error_alineacion sticky flag, set by a misaligned branch target
// ---------------------------------------------------------------------------------------------
module etapa_fetch #(
    parameter logic [63:0] PC_INICIAL  = 64'h0,
    parameter int unsigned PROFUNDIDAD = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] direccion,
    input  logic [31:0] instruccion_im,
    input  logic        salto,
    input  logic [63:0] destino_salto,
    output logic        inst_valida,
    input  logic        decode_listo,
    output logic [31:0] instruccion,
    output logic [63:0] pc_inst,
    output logic        error_alineacion
);

    localparam int unsigned PtrW = (PROFUNDIDAD > 2) ? 2 : 1;
    localparam int unsigned CntW = (PROFUNDIDAD > 3) ? 3 : 2;
    localparam logic [CntW-1:0] CuentaLlena = CntW'(PROFUNDIDAD);

    typedef enum logic [1:0] {
        StArranque,
        StBuscando,
        StLleno
    } estado_e;

    estado_e             estado_q, estado_d;
    logic [63:0]         pc_q, pc_d;
    logic [CntW-1:0]     cuenta_q, cuenta_d;
    logic [PtrW-1:0]     ptr_lec_q, ptr_lec_d;
    logic [PtrW-1:0]     ptr_esc_q, ptr_esc_d;
    logic                error_q, error_d;
    logic [31:0]         mem_ins_q [PROFUNDIDAD];
    logic [63:0]         mem_pc_q  [PROFUNDIDAD];

    logic                pop;
    logic                push;
    logic                lleno;

    // Pointer advance with wrap at PROFUNDIDAD (depth need not be a power of two).
    function automatic logic [PtrW-1:0] sig_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(PROFUNDIDAD - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign lleno = (cuenta_q == CuentaLlena);
    // A redirect cancels the handshake: the head is flushed rather than delivered.
    assign pop   = (cuenta_q != '0) && decode_listo && !salto;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= StArranque;
        end else begin
            estado_q <= estado_d;
        end
    end

    // FSM: next state
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StArranque: estado_d = StBuscando;
            StBuscando: begin
                if (cuenta_d == CuentaLlena && !pop) begin
                    estado_d = StLleno;
                end
            end
            StLleno: begin
                if (pop) begin
                    estado_d = StBuscando;
                end
            end
            default: estado_d = StArranque;
        endcase
        if (salto) begin
            estado_d = StBuscando;
        end
    end

    // FSM: outputs (enqueue enable)
    always_comb begin
        push = 1'b0;
        if (estado_q == StBuscando && !salto && (!lleno || pop)) begin
            push = 1'b1;
        end
    end

    // Datapath next state
    always_comb begin
        pc_d      = pc_q;
        cuenta_d  = cuenta_q;
        ptr_lec_d = ptr_lec_q;
        ptr_esc_d = ptr_esc_q;
        error_d   = error_q;

        if (salto) begin
            pc_d      = {destino_salto[63:2], 2'b00};
            cuenta_d  = '0;
            ptr_lec_d = '0;
            ptr_esc_d = '0;
            error_d   = error_q || (destino_salto[1:0] != 2'b00);
        end else begin
            if (push) begin
                pc_d      = pc_q + 64'd4;
                ptr_esc_d = sig_ptr(ptr_esc_q);
            end
            if (pop) begin
                ptr_lec_d = sig_ptr(ptr_lec_q);
            end
            case ({push, pop})
                2'b10:   cuenta_d = cuenta_q + CntW'(1);
                2'b01:   cuenta_d = cuenta_q - CntW'(1);
                default: cuenta_d = cuenta_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= PC_INICIAL;
            cuenta_q  <= '0;
            ptr_lec_q <= '0;
            ptr_esc_q <= '0;
            error_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            cuenta_q  <= cuenta_d;
            ptr_lec_q <= ptr_lec_d;
            ptr_esc_q <= ptr_esc_d;
            error_q   <= error_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero until the first fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PROFUNDIDAD); i++) begin
                mem_ins_q[i] <= '0;
                mem_pc_q[i]  <= '0;
            end
        end else if (push) begin
            mem_ins_q[ptr_esc_q] <= instruccion_im;
            mem_pc_q[ptr_esc_q]  <= pc_q;
        end
    end

    assign direccion        = {2'b00, pc_q[63:2]};
    assign inst_valida      = (cuenta_q != '0);
    assign instruccion      = mem_ins_q[ptr_lec_q];
    assign pc_inst          = mem_pc_q[ptr_lec_q];
    assign error_alineacion = error_q;

endmodule

// File: tb/tb_etapa_fetch.sv
// ---------------------------------------------------------------------------------------------
// tb_etapa_fetch: directed self-checking bench for etapa_fetch.
// Instruction memory is modelled as word k holding the value k (low 32 bits of the index).
// ---------------------------------------------------------------------------------------------
module tb_etapa_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] direccion;
    logic [31:0] instruccion_im;
    logic        salto;
    logic [63:0] destino_salto;
    logic        inst_valida;
    logic        decode_listo;
    logic [31:0] instruccion;
    logic [63:0] pc_inst;
    logic        error_alineacion;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign instruccion_im = direccion[31:0];

    etapa_fetch #(
        .PC_INICIAL  (64'h0),
        .PROFUNDIDAD (2)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .direccion        (direccion),
        .instruccion_im   (instruccion_im),
        .salto            (salto),
        .destino_salto    (destino_salto),
        .inst_valida      (inst_valida),
        .decode_listo     (decode_listo),
        .instruccion      (instruccion),
        .pc_inst          (pc_inst),
        .error_alineacion (error_alineacion)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] ins, input logic [63:0] pc);
        check({tag, ".valid"}, 64'(inst_valida), 64'd1);
        check({tag, ".instr"}, 64'(instruccion), 64'(ins));
        check({tag, ".pc"}, pc_inst, pc);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"}, 64'(inst_valida), 64'd0);
        check({tag, ".instr"}, 64'(instruccion), 64'd0);
        check({tag, ".pc"}, pc_inst, 64'd0);
        check({tag, ".err"}, 64'(error_alineacion), 64'd0);
        check({tag, ".dir"}, direccion, 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        salto         = 1'b0;
        destino_salto = '0;
        decode_listo  = 1'b1;

        // Reset state
        #2;
        check_cleared("rst");
        #10;
        reset = 1'b0;

        // Streaming with decode always ready: first valid after the second edge
        tick();
        check("stream.c1.valid", 64'(inst_valida), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_head($sformatf("stream.k%0d", k), 32'(k), 64'(4 * k));
        end

        // Decode stalled for five edges: queue fills, PC holds at 8
        reset        = 1'b1;
        decode_listo = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        check("stall.c1.valid", 64'(inst_valida), 64'd0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check_head($sformatf("stall.c%0d", c), 32'd0, 64'd0);
            if (c >= 3) begin
                check($sformatf("stall.c%0d.dir", c), direccion, 64'd2);
            end
        end
        decode_listo = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_head($sformatf("resume.k%0d", k), 32'(k), 64'(4 * k));
        end

        // Refill to two entries, then branch to 0x40
        decode_listo = 1'b0;
        tick();
        check_head("refill.a", 32'd4, 64'd16);
        check("refill.a.dir", direccion, 64'd6);
        tick();
        check_head("refill.b", 32'd4, 64'd16);
        check("refill.b.dir", direccion, 64'd6);
        salto         = 1'b1;
        destino_salto = 64'h40;
        decode_listo  = 1'b1;
        tick();
        check("br40.flush.valid", 64'(inst_valida), 64'd0);
        check("br40.dir", direccion, 64'd16);
        check("br40.err", 64'(error_alineacion), 64'd0);
        salto = 1'b0;
        tick();
        check_head("br40.first", 32'd16, 64'h40);
        tick();
        check_head("br40.second", 32'd17, 64'h44);

        // Misaligned target: PC aligned down, sticky error
        salto         = 1'b1;
        destino_salto = 64'h42;
        tick();
        check("br42.valid", 64'(inst_valida), 64'd0);
        check("br42.dir", direccion, 64'd16);
        check("br42.err", 64'(error_alineacion), 64'd1);
        salto = 1'b0;
        tick();
        check_head("br42.first", 32'd16, 64'h40);
        salto         = 1'b1;
        destino_salto = 64'h100;
        tick();
        check("br100.err", 64'(error_alineacion), 64'd1);
        check("br100.dir", direccion, 64'h40);
        salto = 1'b0;
        tick();
        check_head("br100.first", 32'h40, 64'h100);
        check("br100.err.hold", 64'(error_alineacion), 64'd1);

        // PC wraps from the top of the address space to zero
        salto         = 1'b1;
        destino_salto = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        check("wrap.dir", direccion, 64'h3FFF_FFFF_FFFF_FFFE);
        salto = 1'b0;
        tick();
        check_head("wrap.a", 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        check_head("wrap.b", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check_head("wrap.c", 32'd0, 64'd0);
        check("wrap.err", 64'(error_alineacion), 64'd1);

        // Asynchronous reset between edges clears outputs at once, then fetch restarts
        #3;
        reset = 1'b1;
        #1;
        check_cleared("arst");
        #1;
        reset = 1'b0;
        tick();
        check("arst.c1.valid", 64'(inst_valida), 64'd0);
        tick();
        check_head("arst.k0", 32'd0, 64'd0);
        tick();
        check_head("arst.k1", 32'd1, 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
